data_sram_like_bridge: RTL

Data-side bus bridge for the MIPS CPU core, directly downstream of the memory-stage load/store decoder.
- Takes the decoder's byte-write mask, replicated write data and address, and runs one SRAM-like transaction per memory instruction (req/addr_ok/data_ok).
- Stalls the pipeline while the transaction is in flight.
- Returns raw 32-bit read data, which the decoder then aligns and extends.
- Holds the result until the whole pipeline is released, so an access is never issued twice.

---
 rtl/data_sram_like_bridge.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/data_sram_like_bridge.sv
//------------------------------------------------------------------------------
// data_sram_like_bridge
//
// Data-side bridge between the memory-stage load/store decoder of the MIPS
// core and an SRAM-like bus (req / addr_ok / data_ok handshake). It issues
// one bus transaction per memory instruction and stalls the pipeline while
// that transaction is in flight. The raw read word is held until the whole
// pipeline is released, so an access is never issued twice.
//
// Parameters:
//   ADDR_W - address width on the CPU and bus sides
//   DATA_W - data width on the CPU and bus sides
//
// Ports:
//   clk, resetn        core clock, asynchronous active-low reset
//   mem_en             M-stage instruction is a load or store
//   mem_wen            byte-write mask (0000 = load)
//   mem_addr           effective address
//   mem_wdata          byte-replicated store data
//   load_size          load width: 0 byte, 1 half, 2 word
//   except_cancel      M-stage exception; suppresses a new access
//   cpu_longest_stall  OR of every pipeline stall request (incl. stall_req)
//   mem_rdata          raw read word handed back to the decoder
//   stall_req          pipeline stall request
//   data_req .. data_wdata      bus request side (registered, except req)
//   data_addr_ok, data_data_ok, data_rdata   bus response side
//------------------------------------------------------------------------------
module data_sram_like_bridge #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              resetn,
   // CPU side
   input  logic              mem_en,
   input  logic [3:0]        mem_wen,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   input  logic [1:0]        load_size,
   input  logic              except_cancel,
   input  logic              cpu_longest_stall,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              stall_req,
   // bus side
   output logic              data_req,
   output logic              data_wr,
   output logic [1:0]        data_size,
   output logic [ADDR_W-1:0] data_addr,
   output logic [DATA_W-1:0] data_wdata,
   input  logic              data_addr_ok,
   input  logic              data_data_ok,
   input  logic [DATA_W-1:0] data_rdata
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] WAIT = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]        state_reg;
   logic [1:0]        state_next;
   logic [ADDR_W-1:0] addr_reg;
   logic [DATA_W-1:0] wdata_reg;
   logic              wr_reg;
   logic [1:0]        size_reg;
   logic [1:0]        size_next;
   logic [DATA_W-1:0] rdata_reg;

   logic              start;
   logic              capture;

   // A new access may only begin from IDLE; mem_en and except_cancel are
   // deliberately not looked at in any other state.
   assign start = (state_reg == IDLE) & mem_en & ~except_cancel;

   // Read data is taken either on a same-cycle addr_ok/data_ok in REQ, or on
   // data_ok in WAIT. A data_ok in REQ without addr_ok is not ours.
   assign capture = ((state_reg == REQ) & data_addr_ok & data_data_ok) |
                    ((state_reg == WAIT) & data_data_ok);

   // Bus transfer size: stores derive it from the byte mask, loads take the
   // decoder's load width. Irregular masks fall back to a full word.
   always_comb begin
      size_next = 2'd2;
      case (mem_wen)
         4'b0000:                              size_next = load_size;
         4'b0001, 4'b0010, 4'b0100, 4'b1000:   size_next = 2'd0;
         4'b0011, 4'b1100:                     size_next = 2'd1;
         default:                              size_next = 2'd2;
      endcase
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (start)
               state_next = REQ;
         end
         REQ: begin
            if (data_addr_ok)
               state_next = data_data_ok ? DONE : WAIT;
         end
         WAIT: begin
            if (data_data_ok)
               state_next = DONE;
         end
         DONE: begin
            // Leave only when the pipeline actually advances; otherwise the
            // same instruction is still in M and must not be re-issued.
            if (!cpu_longest_stall)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg <= IDLE;
         addr_reg  <= '0;
         wdata_reg <= '0;
         wr_reg    <= 1'b0;
         size_reg  <= 2'd0;
         rdata_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (start) begin
            addr_reg  <= mem_addr;
            wdata_reg <= mem_wdata;
            wr_reg    <= |mem_wen;
            size_reg  <= size_next;
         end
         if (capture)
            rdata_reg <= data_rdata;
      end
   end

   // data_req depends on state only, so it cannot combinationally loop back
   // through a slave that derives addr_ok from req.
   assign data_req   = (state_reg == REQ);
   assign data_wr    = wr_reg;
   assign data_size  = size_reg;
   assign data_addr  = addr_reg;
   assign data_wdata = wdata_reg;
   assign mem_rdata  = rdata_reg;

   // start is included so the pipeline freezes in the very cycle the access
   // is launched; DONE does not stall.
   assign stall_req = start | (state_reg == REQ) | (state_reg == WAIT);

endmodule
